cereal_rx: RTL and testbench

- UART receiver, 8N1, LSB first. It is the downstream counterpart of the serial transmitter, so the two can be looped back.
- Recovers bytes from the idle-high serial line and presents each byte with a one-cycle valid strobe.
- Default timing is 9600 baud from the 50 MHz sysclk, matching the transmitter's bit period.

---
 rtl/cereal_pkg.sv | 27 ++
 rtl/cereal_sync.sv | 37 +++
 rtl/cereal_rx.sv | 198 +++++++++++++++++++
 tb/tb_cereal_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cereal_pkg.sv
// -----------------------------------------------------------------------------
// cereal_pkg
// Shared definitions for the cereal serial blocks (receiver and transmitter).
//   - cereal_state_e       : receiver state encoding (IDLE, START, DATA, STOP, BREAK)
//   - DEFAULT_CLKS_PER_BIT : 9600 baud from a 50 MHz sysclk
//   - DATA_BITS            : payload bits per frame (8N1)
//   - majority3()          : 2-of-3 vote used by the oversampling option
// -----------------------------------------------------------------------------
package cereal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } cereal_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DATA_BITS            = 8;

    // 2-of-3 majority vote
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/cereal_sync.sv
// -----------------------------------------------------------------------------
// cereal_sync
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   sysclk    in  1  system clock
//   reset     in  1  synchronous, active-high reset (flops load RESET_VAL)
//   async_in  in  1  asynchronous input
//   sync_out  out 1  input re-timed to sysclk, two cycles of latency
// The reset value defaults to 1 so an idle-high serial line does not look like
// a start bit right after reset.
// -----------------------------------------------------------------------------
module cereal_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic sysclk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Two-stage re-timing chain
    always_ff @(posedge sysclk) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/cereal_rx.sv
// -----------------------------------------------------------------------------
// cereal_rx
// UART receiver, 8N1, LSB first. Counterpart of the cereal transmitter.
// Ports:
//   sysclk     in  1  system clock, rising edge
//   reset      in  1  synchronous, active-high reset
//   rx         in  1  asynchronous serial input, idles high
//   data       out 8  last correctly framed byte
//   valid      out 1  one-cycle pulse when data updates
//   frame_err  out 1  one-cycle pulse when the stop bit is sampled low
//   busy       out 1  high whenever the receiver is not idle
// Parameters:
//   CLKS_PER_BIT  sysclk cycles per bit
//   CNT_W         bit-timer width, 2**CNT_W > CLKS_PER_BIT
// Build option:
//   CEREAL_RX_MAJORITY_EN  each sample becomes a 2-of-3 vote of rx_s at
//                          mid-1, mid and mid+1; decisions move to mid+1.
// -----------------------------------------------------------------------------
module cereal_rx
    import cereal_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 13
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] TIMER_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TIMER_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       INDEX_LAST = 3'(DATA_BITS - 1);

    // With voting, the start check moves one cycle later so that the whole
    // frame's decision grid shifts by one; the data/stop decisions then still
    // fall on BIT_LAST and the timer never runs past it.
`ifdef CEREAL_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] START_CHECK = CNT_W'(CLKS_PER_BIT / 2);
`else
    localparam logic [CNT_W-1:0] START_CHECK = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif

    logic                 rx_s;
    logic                 sample_s;

    cereal_state_e        state_r,  state_nx;
    logic [CNT_W-1:0]     timer_r,  timer_nx;
    logic [2:0]           index_r,  index_nx;
    logic [DATA_BITS-1:0] shift_r,  shift_nx;
    logic [DATA_BITS-1:0] data_r,   data_nx;
    logic                 valid_r,  valid_nx;
    logic                 ferr_r,   ferr_nx;
    logic                 busy_r;

    cereal_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .sysclk   (sysclk),
        .reset    (reset),
        .async_in (rx),
        .sync_out (rx_s)
    );

`ifdef CEREAL_RX_MAJORITY_EN
    logic [1:0] hist_r;

    // Two previous rx_s values; with the current one they form the vote window
    always_ff @(posedge sysclk) begin
        if (reset) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], rx_s};
        end
    end

    assign sample_s = majority3(hist_r[1], hist_r[0], rx_s);
`else
    assign sample_s = rx_s;
`endif

    // Next-state and datapath decode
    always_comb begin
        state_nx = state_r;
        timer_nx = timer_r;
        index_nx = index_r;
        shift_nx = shift_r;
        data_nx  = data_r;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                timer_nx = TIMER_ZERO;
                if (rx_s == 1'b0) begin
                    state_nx = ST_START;
                end else begin
                    state_nx = ST_IDLE;
                end
            end

            ST_START: begin
                if (timer_r == START_CHECK) begin
                    timer_nx = TIMER_ZERO;
                    index_nx = 3'd0;
                    // A start bit that is high again at mid-bit was a glitch
                    if (sample_s == 1'b0) begin
                        state_nx = ST_DATA;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    timer_nx = timer_r + TIMER_ONE;
                end
            end

            ST_DATA: begin
                if (timer_r == BIT_LAST) begin
                    timer_nx          = TIMER_ZERO;
                    shift_nx[index_r] = sample_s;
                    // Index holds at its last value on the way into STOP
                    if (index_r == INDEX_LAST) begin
                        state_nx = ST_STOP;
                    end else begin
                        index_nx = index_r + 3'd1;
                    end
                end else begin
                    timer_nx = timer_r + TIMER_ONE;
                end
            end

            ST_STOP: begin
                if (timer_r == BIT_LAST) begin
                    timer_nx = TIMER_ZERO;
                    if (sample_s == 1'b1) begin
                        data_nx  = shift_r;
                        valid_nx = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = ST_BREAK;
                    end
                end else begin
                    timer_nx = timer_r + TIMER_ONE;
                end
            end

            ST_BREAK: begin
                // Wait out a held-low line before hunting for a start bit again
                timer_nx = TIMER_ZERO;
                if (rx_s == 1'b1) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_BREAK;
                end
            end

            default: begin
                timer_nx = TIMER_ZERO;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            timer_r <= TIMER_ZERO;
            index_r <= 3'd0;
            shift_r <= {DATA_BITS{1'b0}};
            data_r  <= {DATA_BITS{1'b0}};
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            timer_r <= timer_nx;
            index_r <= index_nx;
            shift_r <= shift_nx;
            data_r  <= data_nx;
            valid_r <= valid_nx;
            ferr_r  <= ferr_nx;
            // Registered from the next state so it tracks state_r exactly
            busy_r  <= (state_nx != ST_IDLE);
        end
    end

    assign data      = data_r;
    assign valid     = valid_r;
    assign frame_err = ferr_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_cereal_rx.sv
// -----------------------------------------------------------------------------
// tb_cereal_rx
// Scoreboard bench for cereal_rx at CLKS_PER_BIT=16. The stimulus side acts as
// a serial transmitter and, for every frame it sends, pushes the expected
// receiver event (good byte, or framing error with the held data value) into a
// queue. A monitor pops and compares on every valid/frame_err pulse. Works with
// or without CEREAL_RX_MAJORITY_EN since only event order and content are
// checked.
// -----------------------------------------------------------------------------
module tb_cereal_rx;

    localparam int CPB = 16;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;

    cereal_rx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (5)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic checkn(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // Transmit one frame; the line is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] b, input bit stop);
        exp_t e;
        if (stop) begin
            e.is_err  = 1'b0;
            e.data    = b;
            last_good = b;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end
        exp_q.push_back(e);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge sysclk) begin
        exp_t e;
        if (!reset && (valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse valid=%b frame_err=%b data=%h", valid, frame_err, data);
            end else begin
                e = exp_q.pop_front();
                check1("pulse_exclusive", valid & frame_err, 1'b0);
                check1("pulse_kind_ferr", frame_err, e.is_err);
                check8("pulse_data", data, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        bit         stop;
        int         gap;

        // Reset state
        reset = 1'b1;
        rx    = 1'b1;
        tick(4);
        check8("reset_data", data, 8'h00);
        check1("reset_valid", valid, 1'b0);
        check1("reset_ferr", frame_err, 1'b0);
        check1("reset_busy", busy, 1'b0);
        reset = 1'b0;
        tick(3);

        // Single good frame
        send_frame(8'hA5, 1'b1);
        rx = 1'b1;
        tick(CPB);
        check1("a5_busy_after", busy, 1'b0);
        check8("a5_data_held", data, 8'hA5);
        checkn("a5_queue_empty", exp_q.size(), 0);

        // Short low glitch must be rejected at the start check
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2 * CPB);
        check1("glitch_busy", busy, 1'b0);
        check8("glitch_data", data, last_good);
        checkn("glitch_queue", exp_q.size(), 0);

        // Framing error followed by a held-low line
        send_frame(8'h3C, 1'b0);
        tick(40);
        check1("break_busy_low_line", busy, 1'b1);
        check8("break_data_held", data, 8'hA5);
        checkn("break_queue", exp_q.size(), 0);
        rx = 1'b1;
        tick(5);
        check1("break_busy_released", busy, 1'b0);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        rx = 1'b1;
        tick(CPB);
        checkn("b2b_queue", exp_q.size(), 0);
        check8("b2b_data", data, 8'hFF);

        // Reset in the middle of data bit 4 aborts the frame silently
        b  = 8'h96;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = b[4];
        tick(CPB / 2);
        check1("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        rx    = 1'b1;
        tick(2);
        check8("midreset_data", data, 8'h00);
        check1("midreset_valid", valid, 1'b0);
        check1("midreset_ferr", frame_err, 1'b0);
        check1("midreset_busy", busy, 1'b0);
        reset     = 1'b0;
        last_good = 8'h00;
        tick(CPB);
        send_frame(8'h5A, 1'b1);
        rx = 1'b1;
        tick(CPB);
        check8("after_reset_5a", data, 8'h5A);

        // Loopback-style transmission of 0x81
        send_frame(8'h81, 1'b1);
        rx = 1'b1;
        tick(CPB);
        check8("loopback_81", data, 8'h81);

        // Random frames with occasional bad stop bits and random gaps
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            rx  = 1'b1;
            gap = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
            tick(gap);
        end

        rx = 1'b1;
        tick(3 * CPB);
        checkn("final_queue_empty", exp_q.size(), 0);
        check8("final_data", data, last_good);
        check1("final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
